// File: rtl/key_debounce_pulse_if.sv
// Key conditioner bundle: the raw key toward the block, the conditioned events back out.
interface key_debounce_pulse_if;
  logic i_key;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_long;

  modport master (output i_key, input  o_level, o_press, o_release, o_long);
  modport slave  (input  i_key, output o_level, o_press, o_release, o_long);
endinterface

// File: rtl/key_debounce_pulse.sv
// Debounces one raw push-button and emits a clean level plus press/release/long-press pulses.
module key_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int CNT_W           = 27
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  key_debounce_pulse_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);

  state_t           state, state_nxt;
  logic             sync_q1, sync_q2, k, key_pressed;
  logic [CNT_W-1:0] deb_cnt, deb_nxt, hold_cnt, hold_nxt;
  logic             long_done, long_done_nxt;
  logic             level_nxt, press_nxt, release_nxt, long_nxt;
  logic             level_q, press_q, release_q, long_q;

  // Normalise polarity before the synchronizer so reset can load "released" as 0.
  assign key_pressed = KEY_ACTIVE_LOW ? ~bus.i_key : bus.i_key;
  assign k           = sync_q2;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= key_pressed;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      long_done <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_nxt;
      hold_cnt  <= hold_nxt;
      long_done <= long_done_nxt;
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      long_q    <= long_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (k) state_nxt = PRESS_WAIT;
      PRESS_WAIT:   if (!k) state_nxt = IDLE;
                    else if (deb_cnt == DEB_MAX) state_nxt = HELD;
      HELD:         if (!k) state_nxt = RELEASE_WAIT;
      RELEASE_WAIT: if (k) state_nxt = HELD;
                    else if (deb_cnt == DEB_MAX) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    press_nxt     = (state == PRESS_WAIT)   && (state_nxt == HELD);
    release_nxt   = (state == RELEASE_WAIT) && (state_nxt == IDLE);
    level_nxt     = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
    hold_nxt      = hold_cnt;
    long_done_nxt = long_done;
    long_nxt      = 1'b0;

    // deb_cnt restarts on every state entry, so it can never run past DEB_MAX.
    if (state_nxt != state)
      deb_nxt = '0;
    else if (state == PRESS_WAIT || state == RELEASE_WAIT)
      deb_nxt = deb_cnt + 1'b1;
    else
      deb_nxt = '0;

    if (press_nxt) begin
      hold_nxt      = '0;
      long_done_nxt = 1'b0;
    end else if (state == HELD || state == RELEASE_WAIT) begin
      if (hold_cnt != LONG_MAX) hold_nxt = hold_cnt + 1'b1;
      if (hold_cnt == LONG_MAX && !long_done) begin
        long_nxt      = 1'b1;
        long_done_nxt = 1'b1;
      end
    end else begin
      hold_nxt = '0;
    end
  end

  assign bus.o_level   = level_q;
  assign bus.o_press   = press_q;
  assign bus.o_release = release_q;
  assign bus.o_long    = long_q;

endmodule
